// File: rtl/multicycle_ctrl.sv
`default_nettype none
// ============================================================================
// multicycle_ctrl : control FSM sequencing a multi-cycle datapath build.
// Optional build macro MC_PERF_CNT_EN adds the cycle_cnt / instr_cnt counters.
// Revision: 1.0
// ============================================================================
module multicycle_ctrl #(
  parameter int ADDR_W = 32
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       run,
  input  logic [5:0] opcode,
  input  logic       mem_ready,
  output logic       pc_write,
  output logic       pc_write_cond,
  output logic [1:0] pc_source,
  output logic       i_or_d,
  output logic       mem_read,
  output logic       mem_write,
  output logic       ir_write,
  output logic       reg_dst,
  output logic [1:0] mem_to_reg,
  output logic       reg_write,
  output logic       alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [1:0] alu_op,
  output logic       illegal,
  output logic [3:0] state
`ifdef MC_PERF_CNT_EN
  ,
  output logic [ADDR_W-1:0] cycle_cnt,
  output logic [ADDR_W-1:0] instr_cnt
`endif
);

  typedef enum logic [3:0] {
    S_IDLE   = 4'd0,
    S_FETCH  = 4'd1,
    S_DECODE = 4'd2,
    S_MEMADR = 4'd3,
    S_MEMRD  = 4'd4,
    S_MEMWB  = 4'd5,
    S_MEMWR  = 4'd6,
    S_EXEC   = 4'd7,
    S_ALUWB  = 4'd8,
    S_BRANCH = 4'd9,
    S_JUMP   = 4'd10,
    S_IMMEX  = 4'd11,
    S_IMMWB  = 4'd12,
    S_TRAP   = 4'd13
  } state_t;

  typedef enum logic [2:0] {
    C_NONE  = 3'd0,
    C_LW    = 3'd1,
    C_SW    = 3'd2,
    C_RTYPE = 3'd3,
    C_BEQ   = 3'd4,
    C_J     = 3'd5,
    C_ADDI  = 3'd6,
    C_LUI   = 3'd7
  } op_class_t;

  localparam logic [5:0] c_op_rtype = 6'b000000;
  localparam logic [5:0] c_op_j     = 6'b000010;
  localparam logic [5:0] c_op_beq   = 6'b000100;
  localparam logic [5:0] c_op_addi  = 6'b001000;
  localparam logic [5:0] c_op_lui   = 6'b001111;
  localparam logic [5:0] c_op_lw    = 6'b100011;
  localparam logic [5:0] c_op_sw    = 6'b101011;

  // Two-flop synchroniser: assertion is immediate, release is aligned to clk.
  logic r_rst_meta;
  logic r_rst_n;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_rst_meta <= 1'b0;
      r_rst_n    <= 1'b0;
    end else begin
      r_rst_meta <= 1'b1;
      r_rst_n    <= r_rst_meta;
    end
  end

  state_t    r_state;
  state_t    w_next;
  op_class_t r_class;
  op_class_t w_dec_class;
  op_class_t w_class_eff;
  logic      w_terminal;
  logic      w_fetch_done;

  logic       r_pc_write;
  logic       r_pc_write_cond;
  logic [1:0] r_pc_source;
  logic       r_i_or_d;
  logic       r_mem_read;
  logic       r_mem_write;
  logic       r_reg_dst;
  logic [1:0] r_mem_to_reg;
  logic       r_reg_write;
  logic       r_alu_src_a;
  logic [1:0] r_alu_src_b;
  logic [1:0] r_alu_op;
  logic       r_illegal;

  always_comb begin
    w_dec_class = C_NONE;
    case (opcode)
      c_op_lw:    w_dec_class = C_LW;
      c_op_sw:    w_dec_class = C_SW;
      c_op_rtype: w_dec_class = C_RTYPE;
      c_op_beq:   w_dec_class = C_BEQ;
      c_op_j:     w_dec_class = C_J;
      c_op_addi:  w_dec_class = C_ADDI;
      c_op_lui:   w_dec_class = C_LUI;
      default:    w_dec_class = C_NONE;
    endcase
  end

  // The class register only becomes valid after DECODE, so bypass it there.
  assign w_class_eff  = (r_state == S_DECODE) ? w_dec_class : r_class;
  assign w_fetch_done = (r_state == S_FETCH) && mem_ready;
  assign w_terminal   = (r_state inside {S_MEMWB, S_ALUWB, S_BRANCH, S_JUMP, S_IMMWB}) ||
                        ((r_state == S_MEMWR) && mem_ready);

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:   if (run) w_next = S_FETCH;
      S_FETCH:  if (mem_ready) w_next = S_DECODE;
      S_DECODE: begin
        case (w_dec_class)
          C_LW, C_SW: w_next = S_MEMADR;
          C_RTYPE:    w_next = S_EXEC;
          C_BEQ:      w_next = S_BRANCH;
          C_J:        w_next = S_JUMP;
          C_ADDI:     w_next = S_IMMEX;
          C_LUI:      w_next = S_IMMWB;
          default:    w_next = S_TRAP;
        endcase
      end
      S_MEMADR: w_next = (r_class == C_SW) ? S_MEMWR : S_MEMRD;
      S_MEMRD:  if (mem_ready) w_next = S_MEMWB;
      S_EXEC:   w_next = S_ALUWB;
      S_IMMEX:  w_next = S_IMMWB;
      S_TRAP:   w_next = S_TRAP;
      S_MEMWB, S_MEMWR, S_ALUWB, S_BRANCH, S_JUMP, S_IMMWB: w_next = r_state;
      default:  w_next = S_IDLE;
    endcase
    if (w_terminal) begin
      w_next = run ? S_FETCH : S_IDLE;
    end
  end

  // Outputs are registered from the next state so they line up with r_state.
  always_ff @(posedge clk or negedge r_rst_n) begin
    if (!r_rst_n) begin
      r_state         <= S_IDLE;
      r_class         <= C_NONE;
      r_illegal       <= 1'b0;
      r_pc_write      <= 1'b0;
      r_pc_write_cond <= 1'b0;
      r_pc_source     <= 2'b00;
      r_i_or_d        <= 1'b0;
      r_mem_read      <= 1'b0;
      r_mem_write     <= 1'b0;
      r_reg_dst       <= 1'b0;
      r_mem_to_reg    <= 2'b00;
      r_reg_write     <= 1'b0;
      r_alu_src_a     <= 1'b0;
      r_alu_src_b     <= 2'b00;
      r_alu_op        <= 2'b00;
    end else begin
      r_state <= w_next;
      if (r_state == S_DECODE) begin
        r_class <= w_dec_class;
      end
      if (w_next == S_TRAP) begin
        r_illegal <= 1'b1;
      end
      r_pc_write      <= 1'b0;
      r_pc_write_cond <= 1'b0;
      r_pc_source     <= 2'b00;
      r_i_or_d        <= 1'b0;
      r_mem_read      <= 1'b0;
      r_mem_write     <= 1'b0;
      r_reg_dst       <= 1'b0;
      r_mem_to_reg    <= 2'b00;
      r_reg_write     <= 1'b0;
      r_alu_src_a     <= 1'b0;
      r_alu_src_b     <= 2'b00;
      r_alu_op        <= 2'b00;
      case (w_next)
        S_FETCH: begin
          r_mem_read  <= 1'b1;
          r_alu_src_b <= 2'b01;
        end
        S_DECODE: r_alu_src_b <= 2'b11;
        S_MEMADR, S_IMMEX: begin
          r_alu_src_a <= 1'b1;
          r_alu_src_b <= 2'b10;
        end
        S_MEMRD: begin
          r_mem_read <= 1'b1;
          r_i_or_d   <= 1'b1;
        end
        S_MEMWB: begin
          r_mem_to_reg <= 2'b01;
          r_reg_write  <= 1'b1;
        end
        S_MEMWR: begin
          r_mem_write <= 1'b1;
          r_i_or_d    <= 1'b1;
        end
        S_EXEC: begin
          r_alu_src_a <= 1'b1;
          r_alu_op    <= 2'b10;
        end
        S_ALUWB: begin
          r_reg_dst   <= 1'b1;
          r_reg_write <= 1'b1;
        end
        S_BRANCH: begin
          r_alu_src_a     <= 1'b1;
          r_alu_op        <= 2'b01;
          r_pc_write_cond <= 1'b1;
          r_pc_source     <= 2'b01;
        end
        S_JUMP: begin
          r_pc_write  <= 1'b1;
          r_pc_source <= 2'b10;
        end
        S_IMMWB: begin
          r_reg_write  <= 1'b1;
          r_mem_to_reg <= (w_class_eff == C_LUI) ? 2'b10 : 2'b00;
        end
        default: ;
      endcase
    end
  end

  // IR and PC loads in FETCH follow mem_ready in the same cycle.
  assign pc_write      = r_pc_write | w_fetch_done;
  assign ir_write      = w_fetch_done;
  assign pc_write_cond = r_pc_write_cond;
  assign pc_source     = r_pc_source;
  assign i_or_d        = r_i_or_d;
  assign mem_read      = r_mem_read;
  assign mem_write     = r_mem_write;
  assign reg_dst       = r_reg_dst;
  assign mem_to_reg    = r_mem_to_reg;
  assign reg_write     = r_reg_write;
  assign alu_src_a     = r_alu_src_a;
  assign alu_src_b     = r_alu_src_b;
  assign alu_op        = r_alu_op;
  assign illegal       = r_illegal;
  assign state         = r_state;

`ifdef MC_PERF_CNT_EN
  localparam logic [ADDR_W-1:0] c_cnt_one = {{(ADDR_W-1){1'b0}}, 1'b1};

  always_ff @(posedge clk or negedge r_rst_n) begin
    if (!r_rst_n) begin
      cycle_cnt <= '0;
      instr_cnt <= '0;
    end else begin
      if ((r_state != S_IDLE) && (r_state != S_TRAP)) begin
        cycle_cnt <= cycle_cnt + c_cnt_one;
      end
      if (w_terminal) begin
        instr_cnt <= instr_cnt + c_cnt_one;
      end
    end
  end
`else
  // ADDR_W only sizes the performance counters, which are absent here.
  generate
    if (ADDR_W > 0) begin : g_no_perf_cnt
    end
  endgenerate
`endif

endmodule
`default_nettype wire

// File: tb/tb_multicycle_ctrl.sv
`default_nettype none
// ============================================================================
// tb_multicycle_ctrl : directed vector table plus reset / trap corner cases.
// Revision: 1.0
// ============================================================================
module tb_multicycle_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic       run;
  logic [5:0] opcode;
  logic       mem_ready;
  logic       pc_write, pc_write_cond, i_or_d, mem_read, mem_write, ir_write;
  logic       reg_dst, reg_write, alu_src_a, illegal;
  logic [1:0] pc_source, mem_to_reg, alu_src_b, alu_op;
  logic [3:0] state;
`ifdef MC_PERF_CNT_EN
  logic [31:0] cycle_cnt, instr_cnt;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  multicycle_ctrl #(.ADDR_W(32)) dut (
    .clk(clk), .rst(rst), .run(run), .opcode(opcode), .mem_ready(mem_ready),
    .pc_write(pc_write), .pc_write_cond(pc_write_cond), .pc_source(pc_source),
    .i_or_d(i_or_d), .mem_read(mem_read), .mem_write(mem_write), .ir_write(ir_write),
    .reg_dst(reg_dst), .mem_to_reg(mem_to_reg), .reg_write(reg_write),
    .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .alu_op(alu_op),
    .illegal(illegal), .state(state)
`ifdef MC_PERF_CNT_EN
    , .cycle_cnt(cycle_cnt), .instr_cnt(instr_cnt)
`endif
  );

  typedef struct packed {
    logic       pc_write;
    logic       pc_write_cond;
    logic [1:0] pc_source;
    logic       i_or_d;
    logic       mem_read;
    logic       mem_write;
    logic       ir_write;
    logic       reg_dst;
    logic [1:0] mem_to_reg;
    logic       reg_write;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] alu_op;
    logic       illegal;
  } ctl_t;

  ctl_t dut_ctl;
  assign dut_ctl = {pc_write, pc_write_cond, pc_source, i_or_d, mem_read, mem_write,
                    ir_write, reg_dst, mem_to_reg, reg_write, alu_src_a, alu_src_b,
                    alu_op, illegal};

  // Expected control word for a state, from the per-state output table.
  function automatic ctl_t ctl_for(input logic [3:0] st, input logic rdy, input logic lui);
    ctl_t c = '0;
    case (st)
      4'd1:  begin c.mem_read = 1'b1; c.alu_src_b = 2'b01; c.ir_write = rdy; c.pc_write = rdy; end
      4'd2:  c.alu_src_b = 2'b11;
      4'd3:  begin c.alu_src_a = 1'b1; c.alu_src_b = 2'b10; end
      4'd4:  begin c.mem_read = 1'b1; c.i_or_d = 1'b1; end
      4'd5:  begin c.mem_to_reg = 2'b01; c.reg_write = 1'b1; end
      4'd6:  begin c.mem_write = 1'b1; c.i_or_d = 1'b1; end
      4'd7:  begin c.alu_src_a = 1'b1; c.alu_op = 2'b10; end
      4'd8:  begin c.reg_dst = 1'b1; c.reg_write = 1'b1; end
      4'd9:  begin c.alu_src_a = 1'b1; c.alu_op = 2'b01; c.pc_write_cond = 1'b1; c.pc_source = 2'b01; end
      4'd10: begin c.pc_write = 1'b1; c.pc_source = 2'b10; end
      4'd11: begin c.alu_src_a = 1'b1; c.alu_src_b = 2'b10; end
      4'd12: begin c.reg_write = 1'b1; c.mem_to_reg = lui ? 2'b10 : 2'b00; end
      4'd13: c.illegal = 1'b1;
      default: ;
    endcase
    return c;
  endfunction

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, got, exp, $time);
    end
  endtask

  typedef struct {
    logic       run;
    logic [5:0] op;
    logic       rdy;
    logic [3:0] st;
    logic       lui;
  } vec_t;

  function automatic vec_t mk(input logic r, input logic [5:0] o, input logic m,
                              input logic [3:0] s, input logic l);
    vec_t v;
    v.run = r; v.op = o; v.rdy = m; v.st = s; v.lui = l;
    return v;
  endfunction

  vec_t vecs[$];

  initial begin
    // run, opcode, mem_ready -> expected state in that cycle (outputs via ctl_for)
    vecs.push_back(mk(0, 6'h00, 0, 4'd0,  0));  // idle, run low
    vecs.push_back(mk(1, 6'h00, 0, 4'd0,  0));  // run rises
    vecs.push_back(mk(1, 6'h00, 1, 4'd1,  0));  // R-type 0x012A4020
    vecs.push_back(mk(1, 6'h00, 1, 4'd2,  0));
    vecs.push_back(mk(1, 6'h00, 1, 4'd7,  0));  // mem_ready ignored
    vecs.push_back(mk(1, 6'h00, 1, 4'd8,  0));
    vecs.push_back(mk(1, 6'h23, 1, 4'd1,  0));  // lw, 2 wait cycles
    vecs.push_back(mk(1, 6'h23, 0, 4'd2,  0));
    vecs.push_back(mk(1, 6'h23, 0, 4'd3,  0));
    vecs.push_back(mk(1, 6'h23, 0, 4'd4,  0));
    vecs.push_back(mk(1, 6'h23, 0, 4'd4,  0));
    vecs.push_back(mk(1, 6'h23, 1, 4'd4,  0));
    vecs.push_back(mk(1, 6'h23, 0, 4'd5,  0));
    vecs.push_back(mk(1, 6'h2B, 0, 4'd1,  0));  // sw, fetch wait
    vecs.push_back(mk(1, 6'h2B, 1, 4'd1,  0));
    vecs.push_back(mk(1, 6'h2B, 0, 4'd2,  0));
    vecs.push_back(mk(1, 6'h2B, 0, 4'd3,  0));
    vecs.push_back(mk(1, 6'h2B, 0, 4'd6,  0));
    vecs.push_back(mk(1, 6'h2B, 1, 4'd6,  0));
    vecs.push_back(mk(1, 6'h04, 1, 4'd1,  0));  // beq
    vecs.push_back(mk(1, 6'h04, 1, 4'd2,  0));
    vecs.push_back(mk(1, 6'h04, 1, 4'd9,  0));
    vecs.push_back(mk(1, 6'h02, 1, 4'd1,  0));  // j
    vecs.push_back(mk(1, 6'h02, 0, 4'd2,  0));
    vecs.push_back(mk(1, 6'h02, 0, 4'd10, 0));
    vecs.push_back(mk(1, 6'h08, 1, 4'd1,  0));  // addi, run low mid-flight
    vecs.push_back(mk(0, 6'h08, 0, 4'd2,  0));
    vecs.push_back(mk(0, 6'h08, 0, 4'd11, 0));
    vecs.push_back(mk(1, 6'h08, 0, 4'd12, 0));
    vecs.push_back(mk(1, 6'h0F, 1, 4'd1,  0));  // lui, then stop
    vecs.push_back(mk(1, 6'h0F, 0, 4'd2,  0));
    vecs.push_back(mk(0, 6'h0F, 0, 4'd12, 1));
    vecs.push_back(mk(0, 6'h00, 0, 4'd0,  0));
    vecs.push_back(mk(0, 6'h00, 1, 4'd0,  0));

    rst = 1'b0; run = 1'b0; opcode = 6'h00; mem_ready = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_state", 32'(state), 32'd0);
    check("reset_outputs", 32'(dut_ctl), 32'd0);
    rst = 1'b1;
    repeat (4) @(posedge clk);
    @(negedge clk);
    check("post_reset_idle_state", 32'(state), 32'd0);
    check("post_reset_idle_outputs", 32'(dut_ctl), 32'd0);
    @(posedge clk); #1;

    for (int i = 0; i < vecs.size(); i++) begin
      run = vecs[i].run; opcode = vecs[i].op; mem_ready = vecs[i].rdy;
      @(negedge clk);
      check($sformatf("vec%0d_state", i), 32'(state), 32'(vecs[i].st));
      check($sformatf("vec%0d_ctl", i), 32'(dut_ctl),
            32'(ctl_for(vecs[i].st, vecs[i].rdy, vecs[i].lui)));
      @(posedge clk); #1;
    end

    // Undefined opcode: TRAP is absorbing until reset.
    run = 1'b1; mem_ready = 1'b1; opcode = 6'h3F;
    repeat (3) begin @(posedge clk); #1; end
    for (int i = 0; i < 20; i++) begin
      run = 1'($urandom_range(0, 1)); mem_ready = 1'($urandom_range(0, 1));
      @(negedge clk);
      check($sformatf("trap%0d_state", i), 32'(state), 32'd13);
      check($sformatf("trap%0d_ctl", i), 32'(dut_ctl), 32'(ctl_for(4'd13, 1'b0, 1'b0)));
      @(posedge clk); #1;
    end
    rst = 1'b0; #1;
    check("trap_reset_state", 32'(state), 32'd0);
    check("trap_reset_illegal", 32'(illegal), 32'd0);
    run = 1'b0;
    repeat (2) @(posedge clk);
    rst = 1'b1;
    repeat (4) @(posedge clk);
    #1;

    // Reset asserted while a store waits for memory.
    run = 1'b1; mem_ready = 1'b1; opcode = 6'h2B;
    @(posedge clk); #1;
    @(posedge clk); #1;
    mem_ready = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    @(negedge clk);
    check("memwr_state", 32'(state), 32'd6);
    check("memwr_mem_write", 32'(mem_write), 32'd1);
    #1 rst = 1'b0;
    #1;
    check("abort_mem_write", 32'(mem_write), 32'd0);
    check("abort_state", 32'(state), 32'd0);
    check("abort_outputs", 32'(dut_ctl), 32'd0);
`ifdef MC_PERF_CNT_EN
    check("abort_cycle_cnt", cycle_cnt, 32'd0);
    check("abort_instr_cnt", instr_cnt, 32'd0);
`endif
    repeat (2) @(posedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
